// File: rtl/dino_pkg.sv
// Shared types and glyph geometry for the score display path.
// Glyphs are 4x4 cell bitmaps; scores are 14-bit binary, up to four BCD digits.
package dino_pkg;

    localparam int unsigned GLYPH_W    = 4;
    localparam int unsigned GLYPH_H    = 4;
    localparam int unsigned SCORE_BITS = 14;
    localparam int unsigned BCD_DIGITS = 4;
    localparam int unsigned BCD_BITS   = BCD_DIGITS * 4;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        COMMIT
    } conv_state_e;

    // Largest value representable in the given number of decimal digits.
    function automatic int unsigned max_score(input int unsigned digits);
        int unsigned v;
        v = 1;
        for (int unsigned i = 0; i < digits; i++) begin
            v = v * 10;
        end
        return v - 1;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter: one shift-add-3 step per clock.
// start loads a new value (and cancels any conversion in flight); done pulses once at the end.
module bin2bcd_seq
    import dino_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [SCORE_BITS-1:0] value,
    output logic                  busy,
    output logic                  done,
    output logic [BCD_BITS-1:0]   bcd
);

    localparam logic [3:0] LAST_ITER = 4'(SCORE_BITS - 1);

    logic [SCORE_BITS-1:0] bin_q, bin_d;
    logic [BCD_BITS-1:0]   bcd_q, bcd_d;
    logic [BCD_BITS-1:0]   adj;
    logic [3:0]            cnt_q, cnt_d;
    logic                  run_q, run_d;
    logic                  done_q, done_d;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < int'(BCD_DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = 1'b0;
        if (start) begin
            bin_d = value;
            bcd_d = '0;
            cnt_d = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            {bcd_d, bin_d} = {adj, bin_q} << 1;
            cnt_d          = cnt_q + 4'd1;
            if (cnt_q == LAST_ITER) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign busy = run_q;
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/score_render_ctrl.sv
// Score overlay: converts a loaded binary score to BCD and renders it as scaled 4x4 glyphs
// into the VGA raster through an external font ROM, with a 3-cycle pixel pipeline.
module score_render_ctrl
    import dino_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned X0         = 560,
    parameter int unsigned Y0         = 16,
    parameter int unsigned SCALE_LOG2 = 2,
    parameter bit          BLANK_LZ   = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] score_in,
    input  logic        score_load,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    output logic [3:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic        pixel_on,
    output logic        busy
);

    localparam int unsigned DIGIT_PIX = GLYPH_W << SCALE_LOG2;
    localparam int unsigned FIELD_H   = GLYPH_H << SCALE_LOG2;
    localparam int unsigned DIG_SHIFT = $clog2(GLYPH_W) + SCALE_LOG2;
    localparam logic [10:0] X_LO      = 11'(X0);
    localparam logic [10:0] X_HI      = 11'(X0 + NUM_DIGITS * DIGIT_PIX);
    localparam logic [9:0]  Y_LO      = 10'(Y0);
    localparam logic [9:0]  Y_HI      = 10'(Y0 + FIELD_H);
    localparam logic [1:0]  MSD_NIB   = 2'(NUM_DIGITS - 1);
    localparam logic [SCORE_BITS-1:0] SCORE_MAX = SCORE_BITS'(max_score(NUM_DIGITS));

    // ---------------- conversion control ----------------
    conv_state_e           state_q, state_d;
    logic                  armed_q;
    logic                  load_ok;
    logic                  conv_start;
    logic                  commit;
    logic                  conv_busy;
    logic                  conv_done;
    logic [BCD_BITS-1:0]   conv_bcd;
    logic [BCD_BITS-1:0]   disp_q;
    logic [SCORE_BITS-1:0] load_value;

    // armed_q masks score_load on the first edge after reset release.
    assign load_ok    = score_load & armed_q;
    assign load_value = (score_in > SCORE_MAX) ? SCORE_MAX : score_in;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (conv_start),
        .value (load_value),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_comb begin
        state_d    = state_q;
        conv_start = 1'b0;
        commit     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load_ok) begin
                    conv_start = 1'b1;
                    state_d    = CONVERT;
                end
            end
            CONVERT: begin
                if (load_ok) begin
                    conv_start = 1'b1;
                end else if (conv_done && !conv_busy) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                if (load_ok) begin
                    conv_start = 1'b1;
                    state_d    = CONVERT;
                end else begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            armed_q <= 1'b0;
            disp_q  <= '0;
        end else begin
            state_q <= state_d;
            armed_q <= 1'b1;
            if (commit) begin
                disp_q <= conv_bcd;
            end
        end
    end

    assign busy = (state_q != IDLE);

    // ---------------- render pipeline ----------------
    logic [10:0] rel_x;
    logic [9:0]  rel_y;
    logic        in_field;
    logic [1:0]  dig_idx;
    logic [1:0]  cell_col;
    logic [1:0]  cell_row;
    logic [1:0]  nib_sel;
    logic [3:0]  glyph_sel;
    logic [3:0]  lz;
    logic        seen_nz;
    logic [1:0]  s1_nib;
    logic        blank_s1;
    logic        glyph_bit;

    logic        s1_valid;
    logic [1:0]  s1_dig;
    logic [1:0]  s1_col;
    logic [1:0]  s1_row;
    logic        s2_valid;
    logic [1:0]  s2_col;
    logic [1:0]  s2_row;
    logic        s2_blank;

    always_comb begin
        rel_x     = hcount - X_LO;
        rel_y     = vcount - Y_LO;
        in_field  = (hcount >= X_LO) && (hcount < X_HI) && (vcount >= Y_LO) && (vcount < Y_HI);
        dig_idx   = 2'(rel_x >> DIG_SHIFT);
        cell_col  = 2'(rel_x >> SCALE_LOG2);
        cell_row  = 2'(rel_y >> SCALE_LOG2);
        // Digit 0 is leftmost, i.e. the most significant displayed nibble.
        nib_sel   = MSD_NIB - dig_idx;
        glyph_sel = disp_q[{nib_sel, 2'b00} +: 4];
    end

    // lz[p] marks nibble p as a leading zero; the ones nibble is never marked.
    always_comb begin
        lz      = '0;
        seen_nz = 1'b0;
        for (int p = 3; p >= 1; p--) begin
            if (p < int'(NUM_DIGITS)) begin
                if (disp_q[4*p +: 4] != 4'd0) begin
                    seen_nz = 1'b1;
                end
                lz[p] = ~seen_nz;
            end
        end
    end

    always_comb begin
        s1_nib    = MSD_NIB - s1_dig;
        blank_s1  = BLANK_LZ && lz[s1_nib];
        glyph_bit = rom_data[4'd15 - {s2_row, s2_col}];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_dig   <= '0;
            s1_col   <= '0;
            s1_row   <= '0;
            rom_addr <= '0;
            s2_valid <= 1'b0;
            s2_col   <= '0;
            s2_row   <= '0;
            s2_blank <= 1'b0;
            pixel_on <= 1'b0;
        end else begin
            s1_valid <= in_field;
            s1_dig   <= dig_idx;
            s1_col   <= cell_col;
            s1_row   <= cell_row;
            if (in_field) begin
                rom_addr <= glyph_sel;
            end
            s2_valid <= s1_valid;
            s2_col   <= s1_col;
            s2_row   <= s1_row;
            s2_blank <= blank_s1;
            pixel_on <= s2_valid & glyph_bit & ~s2_blank;
        end
    end

endmodule
